// File: rtl/fetcher.sv
// Instruction fetcher with a one-entry instruction buffer in front of program memory.
// Hits complete in one cycle; misses issue a single read and wait for mem_read_ready.
module fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    localparam logic [2:0] IDLE     = 3'b000;
    localparam logic [2:0] FETCHING = 3'b001;
    localparam logic [2:0] FETCHED  = 3'b010;

    logic [2:0]                       state;
    logic [2:0]                       next_state;
    logic                             buf_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_tag;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;
    logic                             lookup;
    logic                             hit;

    // A flush in the lookup cycle forces a miss so stale code is never served.
    assign lookup = (state == IDLE) && (core_state == CORE_FETCH);
    assign hit    = buf_valid && (buf_tag == current_pc) && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:     next_state = lookup ? (hit ? FETCHED : FETCHING) : IDLE;
            FETCHING: next_state = mem_read_ready ? FETCHED : FETCHING;
            FETCHED:  next_state = (core_state == CORE_DECODE) ? IDLE : FETCHED;
            default:  next_state = IDLE;
        endcase
    end

    // The request is a pure function of state, so only one can ever be outstanding.
    always_comb begin
        mem_read_valid = (state == FETCHING);
        fetcher_state  = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_address <= '0;
            instruction      <= '0;
            buf_valid        <= 1'b0;
            buf_tag          <= '0;
            buf_data         <= '0;
            hit_count        <= 16'd0;
            miss_count       <= 16'd0;
        end else begin
            if (lookup) begin
                if (hit) begin
                    instruction <= buf_data;
                    if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else begin
                    mem_read_address <= current_pc;
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                end
            end
            if ((state == FETCHING) && mem_read_ready) begin
                instruction <= mem_read_data;
                if (!flush) begin
                    buf_valid <= 1'b1;
                    buf_tag   <= mem_read_address;
                    buf_data  <= mem_read_data;
                end
            end
            // Placed last so a flush overrides any fill in the same cycle.
            if (flush) buf_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: miss, hit, flush, reset mid-fetch, handshake and counter saturation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetcher;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] C_IDLE   = 3'b000;
    localparam logic [2:0] C_FETCH  = 3'b001;
    localparam logic [2:0] C_DECODE = 3'b010;
    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;

    fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .flush            (flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One zero-wait miss: FETCH, ready in the first FETCHING cycle, then DECODE.
    task automatic do_miss(input logic [7:0] pc, input logic [15:0] data);
        core_state = C_FETCH; current_pc = pc;
        step();
        core_state = C_IDLE; mem_read_ready = 1'b1; mem_read_data = data;
        step();
        mem_read_ready = 1'b0; core_state = C_DECODE;
        step();
        core_state = C_IDLE;
    endtask

    initial begin
        reset = 1'b1; core_state = C_IDLE; current_pc = 8'h00; flush = 1'b0;
        mem_read_ready = 1'b0; mem_read_data = 16'h0000;
        step(); step();
        reset = 1'b0;
        chk("rst_state", fetcher_state, S_IDLE);
        chk("rst_valid", mem_read_valid, 0);
        chk("rst_addr", mem_read_address, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_miss", miss_count, 0);

        // Miss with three request cycles before ready.
        core_state = C_FETCH; current_pc = 8'h05;
        step();
        core_state = C_IDLE;
        chk("miss_state", fetcher_state, S_FETCHING);
        chk("miss_valid1", mem_read_valid, 1);
        chk("miss_addr1", mem_read_address, 8'h05);
        chk("miss_cnt1", miss_count, 1);
        current_pc = 8'h33;
        step();
        chk("miss_valid2", mem_read_valid, 1);
        chk("miss_addr2", mem_read_address, 8'h05);
        step();
        chk("miss_valid3", mem_read_valid, 1);
        chk("miss_addr3", mem_read_address, 8'h05);
        mem_read_ready = 1'b1; mem_read_data = 16'h9123;
        step();
        mem_read_ready = 1'b0;
        chk("miss_done_state", fetcher_state, S_FETCHED);
        chk("miss_done_valid", mem_read_valid, 0);
        chk("miss_done_instr", instruction, 16'h9123);

        // FETCH held in FETCHED, plus a stray ready, must not start a new request.
        core_state = C_FETCH; current_pc = 8'h05;
        step();
        chk("hold_state", fetcher_state, S_FETCHED);
        chk("hold_valid", mem_read_valid, 0);
        chk("hold_miss", miss_count, 1);
        mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
        step();
        mem_read_ready = 1'b0;
        chk("stray_ready_state", fetcher_state, S_FETCHED);
        chk("stray_ready_instr", instruction, 16'h9123);
        core_state = C_DECODE;
        step();
        core_state = C_IDLE;
        chk("decode_state", fetcher_state, S_IDLE);
        chk("idle_instr", instruction, 16'h9123);
        step();
        chk("idle_stay", fetcher_state, S_IDLE);
        chk("idle_novalid", mem_read_valid, 0);

        // Hit on the buffered pc.
        core_state = C_FETCH; current_pc = 8'h05;
        step();
        chk("hit_state", fetcher_state, S_FETCHED);
        chk("hit_valid", mem_read_valid, 0);
        chk("hit_instr", instruction, 16'h9123);
        chk("hit_cnt", hit_count, 1);
        chk("hit_miss", miss_count, 1);
        core_state = C_DECODE;
        step();

        // Flush pulse, then refetch misses; flush with ready leaves buffer empty.
        core_state = C_IDLE; flush = 1'b1;
        step();
        flush = 1'b0; core_state = C_FETCH;
        step();
        chk("flush_state", fetcher_state, S_FETCHING);
        chk("flush_valid", mem_read_valid, 1);
        chk("flush_miss", miss_count, 2);
        core_state = C_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'h1234; flush = 1'b1;
        step();
        mem_read_ready = 1'b0; flush = 1'b0;
        chk("flushrdy_state", fetcher_state, S_FETCHED);
        chk("flushrdy_instr", instruction, 16'h1234);
        core_state = C_DECODE;
        step();
        core_state = C_FETCH;
        step();
        chk("nofill_state", fetcher_state, S_FETCHING);
        chk("nofill_miss", miss_count, 3);
        core_state = C_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'h4321;
        step();
        mem_read_ready = 1'b0; core_state = C_DECODE;
        step();

        // Flush coincident with lookup forces a miss even though the buffer matches.
        core_state = C_FETCH; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flushlk_state", fetcher_state, S_FETCHING);
        chk("flushlk_miss", miss_count, 4);
        core_state = C_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'h4321;
        step();
        mem_read_ready = 1'b0; core_state = C_DECODE;
        step();
        core_state = C_FETCH;
        step();
        chk("hit2_state", fetcher_state, S_FETCHED);
        chk("hit2_instr", instruction, 16'h4321);
        chk("hit2_cnt", hit_count, 2);
        core_state = C_DECODE;
        step();

        // Different pc misses and replaces the buffer entry.
        do_miss(8'h06, 16'h0666);
        chk("pc6_instr", instruction, 16'h0666);
        chk("pc6_miss", miss_count, 5);
        core_state = C_FETCH; current_pc = 8'h05;
        step();
        chk("evict_state", fetcher_state, S_FETCHING);
        chk("evict_addr", mem_read_address, 8'h05);
        chk("evict_miss", miss_count, 6);
        core_state = C_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'h4321;
        step();
        mem_read_ready = 1'b0; core_state = C_DECODE;
        step();

        // Reset in FETCHING abandons the request; a stale ready is ignored.
        core_state = C_FETCH; current_pc = 8'h10;
        step();
        chk("rmid_state", fetcher_state, S_FETCHING);
        chk("rmid_addr", mem_read_address, 8'h10);
        reset = 1'b1; core_state = C_IDLE;
        step();
        reset = 1'b0;
        chk("rmid_idle", fetcher_state, S_IDLE);
        chk("rmid_valid", mem_read_valid, 0);
        chk("rmid_miss", miss_count, 0);
        chk("rmid_hit", hit_count, 0);
        mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
        step();
        mem_read_ready = 1'b0;
        chk("stale_state", fetcher_state, S_IDLE);
        chk("stale_instr", instruction, 0);
        core_state = C_FETCH; current_pc = 8'h00;
        step();
        chk("rst_buf_miss", fetcher_state, S_FETCHING);
        core_state = C_IDLE; mem_read_ready = 1'b1; mem_read_data = 16'h0A0A;
        step();
        mem_read_ready = 1'b0; core_state = C_DECODE;
        step();
        core_state = C_IDLE;

        // Saturation: preload the counters near the top instead of issuing 65k misses.
        force dut.miss_count = 16'hFFFC;
        #1;
        release dut.miss_count;
        do_miss(8'h01, 16'h0001);
        chk("sat_miss1", miss_count, 16'hFFFD);
        do_miss(8'h00, 16'h0002);
        chk("sat_miss2", miss_count, 16'hFFFE);
        do_miss(8'h01, 16'h0003);
        chk("sat_miss3", miss_count, 16'hFFFF);
        do_miss(8'h00, 16'h0004);
        chk("sat_miss4", miss_count, 16'hFFFF);
        force dut.hit_count = 16'hFFFF;
        #1;
        release dut.hit_count;
        core_state = C_FETCH; current_pc = 8'h00;
        step();
        chk("sat_hit_state", fetcher_state, S_FETCHED);
        chk("sat_hit_instr", instruction, 16'h0004);
        chk("sat_hit", hit_count, 16'hFFFF);
        core_state = C_DECODE;
        step();
        core_state = C_IDLE;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8: width of the program-memory address and the PC.
REQ-002 Parameter PROGRAM_MEM_DATA_BITS, default 16: width of the instruction word.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 core_state  input  3  scheduler state. FETCH = 3'b001, DECODE = 3'b010.
REQ-006 current_pc  input  PROGRAM_MEM_ADDR_BITS  address of the instruction to fetch.
REQ-007 flush  input  1  invalidates the instruction buffer; pulsed at kernel launch.
REQ-008 mem_read_valid  output  1  program-memory read request.
REQ-009 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  program-memory read address.
REQ-010 mem_read_ready  input  1  program memory returns data this cycle.
REQ-011 mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction.
REQ-012 fetcher_state  output  3  encodings: IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010.
REQ-013 instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction; valid while fetcher_state is FETCHED.
REQ-014 hit_count  output  16  buffer-hit counter.
REQ-015 miss_count  output  16  memory-fetch counter.

Function
REQ-016 The block SHALL hold a one-entry instruction buffer: buf_valid (1 bit), buf_tag (PC width) and buf_data (data width).
REQ-017 In IDLE with core_state == FETCH, a hit SHALL occur when buf_valid is set, buf_tag == current_pc and flush is low.
REQ-018 On a hit, the next cycle SHALL have fetcher_state = FETCHED, instruction = buf_data and mem_read_valid = 0; hit_count increments by 1.
REQ-019 On a miss in IDLE with core_state == FETCH, the next cycle SHALL have fetcher_state = FETCHING, mem_read_valid = 1 and mem_read_address = current_pc; miss_count increments by 1.
REQ-020 In IDLE with core_state not equal to FETCH, the block SHALL stay in IDLE with no request.
REQ-021 In FETCHING, mem_read_valid and mem_read_address SHALL stay constant until the cycle in which mem_read_ready is sampled high.
REQ-022 On that cycle the block SHALL clear mem_read_valid, latch instruction = mem_read_data, enter FETCHED, and write buf_tag = mem_read_address, buf_data = mem_read_data and buf_valid = 1.
REQ-023 Exception to REQ-022: if flush is high in that same cycle, the instruction SHALL still be latched and FETCHED entered, but the buffer SHALL NOT be written and buf_valid = 0.
REQ-024 Minimum latency from the FETCH request to FETCHED SHALL be 1 cycle on a hit and 2 cycles on a miss with zero-wait memory (ready in the first FETCHING cycle).
REQ-025 In FETCHED, the block SHALL return to IDLE on the cycle after core_state == DECODE is sampled; otherwise it stays in FETCHED.
REQ-026 instruction SHALL keep its value in IDLE until the next fetch completes.
REQ-027 flush SHALL clear buf_valid in any state on the next edge. A flush coincident with a lookup SHALL force a miss.
REQ-028 mem_read_ready SHALL be ignored outside FETCHING.
REQ-029 hit_count and miss_count SHALL saturate at 16'hFFFF and never wrap.
REQ-030 Unused state encodings (3'b011 to 3'b111) SHALL return to IDLE on the next edge with mem_read_valid = 0.
REQ-031 At most one outstanding memory request SHALL exist at any time.

Reset
REQ-032 While reset is high, the next edge SHALL set fetcher_state = IDLE, mem_read_valid = 0, mem_read_address = 0, instruction = 0, buf_valid = 0, buf_tag = 0, buf_data = 0, hit_count = 0 and miss_count = 0.
REQ-033 Reset asserted in FETCHING SHALL abandon the request: mem_read_valid = 0 the next cycle, and a later mem_read_ready is ignored.
REQ-034 reset SHALL take priority over flush, core_state and mem_read_ready.

Verification
REQ-035 Miss with memory delay: pc = 0x05, core_state = FETCH, memory ready after 3 cycles with data 16'h9123 -> mem_read_valid = 1 and address 0x05 for 3 cycles; then FETCHED with instruction = 16'h9123; miss_count = 1.
REQ-036 Hit: repeat pc = 0x05 after DECODE -> FETCHED one cycle after FETCH, mem_read_valid never asserted, instruction = 16'h9123, hit_count = 1.
REQ-037 Flush: pulse flush, then FETCH at pc = 0x05 -> miss with a memory request; miss_count = 2. Flush coincident with ready -> buf_valid = 0 afterwards.
REQ-038 Reset mid-fetch: reset in FETCHING at pc = 0x10 -> IDLE with mem_read_valid = 0; a stale ready on the next cycle causes no state change and instruction = 0.
REQ-039 Saturation: force 65537 misses on alternating pcs 0x00 and 0x01 -> miss_count = 16'hFFFF.
REQ-040 Handshake: hold core_state = FETCH in FETCHED -> the block stays in FETCHED with no new request until DECODE is seen.
